// File: rtl/sfifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable registered or
// first-word-fall-through read data.
module sfifo_prog #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_winc,
  input  logic                  i_rinc,
  input  logic [ADDR_WIDTH:0]   i_afull_thresh,
  input  logic [ADDR_WIDTH:0]   i_aempty_thresh,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_wfull,
  output logic                  o_wfull_almost,
  output logic                  o_rempty,
  output logic                  o_rempty_almost,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LVL_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wacc;
  logic                  racc;

  // Status decodes straight from the occupancy counter; an out-of-range
  // almost-full threshold can never be reached, so no special case is needed.
  assign o_wfull         = (o_level == LVL_W'(DEPTH));
  assign o_rempty        = (o_level == '0);
  assign o_wfull_almost  = (o_level >= i_afull_thresh);
  assign o_rempty_almost = (o_level <= i_aempty_thresh);

  // Requests are qualified against the pre-edge flags only.
  assign wacc = i_winc & ~o_wfull;
  assign racc = i_rinc & ~o_rempty;

  // Storage array: deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wacc) begin
      mem[wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wacc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (racc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
    end
  end

  // Occupancy counter; a simultaneous accepted write and read cancel out.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_level <= '0;
    end else if (wacc && !racc) begin
      o_level <= o_level + LVL_W'(1);
    end else if (racc && !wacc) begin
      o_level <= o_level - LVL_W'(1);
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (o_overflow  & ~i_clr_err) | (i_winc & o_wfull);
      o_underflow <= (o_underflow & ~i_clr_err) | (i_rinc & o_rempty);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is presented combinationally.
      assign o_rdata = mem[rd_ptr];
    end else begin : g_reg
      // Head entry is captured on an accepted read and held otherwise.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          o_rdata <= '0;
        end else if (racc) begin
          o_rdata <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sfifo_prog.sv
// Bench for sfifo_prog: a registered-read and a FWFT instance share stimulus
// and are compared against a queue-based model of the FIFO.
module tb_sfifo_prog;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [7:0] i_wdata;
  logic       i_winc, i_rinc, i_clr_err;
  logic [4:0] i_afull_thresh, i_aempty_thresh;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, wfull1, wfa0, wfa1, rempty0, rempty1, rea0, rea1;
  logic [4:0] level0, level1;
  logic       ovf0, ovf1, unf0, unf1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_rreg = 8'h00;

  always #5 i_clk = ~i_clk;

  sfifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)) dut0 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wdata(i_wdata), .i_winc(i_winc),
    .i_rinc(i_rinc), .i_afull_thresh(i_afull_thresh), .i_aempty_thresh(i_aempty_thresh),
    .i_clr_err(i_clr_err), .o_rdata(rdata0), .o_wfull(wfull0), .o_wfull_almost(wfa0),
    .o_rempty(rempty0), .o_rempty_almost(rea0), .o_level(level0),
    .o_overflow(ovf0), .o_underflow(unf0));

  sfifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1)) dut1 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wdata(i_wdata), .i_winc(i_winc),
    .i_rinc(i_rinc), .i_afull_thresh(i_afull_thresh), .i_aempty_thresh(i_aempty_thresh),
    .i_clr_err(i_clr_err), .o_rdata(rdata1), .o_wfull(wfull1), .o_wfull_almost(wfa1),
    .o_rempty(rempty1), .o_rempty_almost(rea1), .o_level(level1),
    .o_overflow(ovf1), .o_underflow(unf1));

  // One clock of stimulus; the model advances with FIFO rules at the edge.
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit clr);
    int  n     = q.size();
    bit  full  = (n == 16);
    bit  empty = (n == 0);
    i_winc = w; i_rinc = r; i_wdata = d; i_clr_err = clr;
    @(posedge i_clk);
    if (r && !empty) m_rreg = q.pop_front();
    if (w && !full) q.push_back(d);
    m_ovf = (m_ovf && !clr) || (w && full);
    m_unf = (m_unf && !clr) || (r && empty);
    #1;
    i_winc = 1'b0; i_rinc = 1'b0; i_clr_err = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rreg = 8'h00;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_winc = 1'b0; i_rinc = 1'b0; i_wdata = 8'h00; i_clr_err = 1'b0;
    i_afull_thresh = 5'd16; i_aempty_thresh = 5'd0;
    model_reset();
    #12;
    n_tests++; if (level0 !== 5'd0 || level1 !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d/%0d expected 0", level0, level1); end
    n_tests++; if (rempty0 !== 1'b1 || wfull0 !== 1'b0 || rea0 !== 1'b1) begin n_fail++; $display("FAIL reset_flags: got rempty=%b wfull=%b rea=%b expected 1 0 1", rempty0, wfull0, rea0); end
    n_tests++; if (ovf0 !== 1'b0 || unf0 !== 1'b0 || rdata0 !== 8'h00) begin n_fail++; $display("FAIL reset_err_rdata: got ovf=%b unf=%b rdata=%h expected 0 0 00", ovf0, unf0, rdata0); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      n_tests++; if (level0 !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_level: got %0d expected %0d", level0, i + 1); end
    end
    n_tests++; if (wfull0 !== 1'b1 || wfull1 !== 1'b1 || level1 !== 5'd16) begin n_fail++; $display("FAIL fill_full: got wfull=%b/%b level1=%0d expected 1/1 16", wfull0, wfull1, level1); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (rdata1 !== 8'(i)) begin n_fail++; $display("FAIL drain_fwft: got %h expected %h", rdata1, 8'(i)); end
      step(1'b0, 1'b1, 8'h00, 1'b0);
      n_tests++; if (rdata0 !== 8'(i)) begin n_fail++; $display("FAIL drain_rdata: got %h expected %h", rdata0, 8'(i)); end
    end
    n_tests++; if (rempty0 !== 1'b1 || rempty1 !== 1'b1 || level0 !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got rempty=%b/%b level=%0d expected 1/1 0", rempty0, rempty1, level0); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0);
      n_tests++; if (level0 !== 5'd8 || level1 !== 5'd8) begin n_fail++; $display("FAIL wrap_level: got %0d/%0d expected 8", level0, level1); end
      n_tests++; if (rdata0 !== m_rreg) begin n_fail++; $display("FAIL wrap_rdata: got %h expected %h", rdata0, m_rreg); end
      n_tests++; if (rdata1 !== q[0]) begin n_fail++; $display("FAIL wrap_fwft: got %h expected %h", rdata1, q[0]); end
    end
  endtask

  task automatic test_boundaries();
    while (q.size() < 16) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    n_tests++; if (level0 !== 5'd15 || ovf0 !== 1'b1 || ovf1 !== 1'b1) begin n_fail++; $display("FAIL full_wr_rd: got level=%0d ovf=%b/%b expected 15 1/1", level0, ovf0, ovf1); end
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    n_tests++; if (level0 !== 5'd1 || unf0 !== 1'b1 || ovf0 !== 1'b1) begin n_fail++; $display("FAIL empty_wr_rd: got level=%0d unf=%b ovf=%b expected 1 1 1", level0, unf0, ovf0); end
    n_tests++; if (rdata1 !== 8'h77) begin n_fail++; $display("FAIL empty_wr_fwft: got %h expected 77", rdata1); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_tests++; if (ovf0 !== 1'b0 || unf0 !== 1'b0 || ovf1 !== 1'b0 || unf1 !== 1'b0) begin n_fail++; $display("FAIL clr_err: got ovf=%b unf=%b expected 0 0", ovf0, unf0); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (rdata0 !== 8'h77) begin n_fail++; $display("FAIL empty_wr_data: got %h expected 77", rdata0); end
    step(1'b0, 1'b1, 8'h00, 1'b1);
    n_tests++; if (unf0 !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got unf=%b expected 1", unf0); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_tests++; if (unf0 !== 1'b0) begin n_fail++; $display("FAIL clr_after_set: got unf=%b expected 0", unf0); end
  endtask

  task automatic test_thresholds();
    i_afull_thresh = 5'd12; i_aempty_thresh = 5'd3;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      n_tests++; if (wfa0 !== (i >= 12) || wfa1 !== (i >= 12)) begin n_fail++; $display("FAIL afull_lvl%0d: got %b expected %b", i, wfa0, i >= 12); end
      n_tests++; if (rea0 !== (i <= 3)) begin n_fail++; $display("FAIL aempty_lvl%0d: got %b expected %b", i, rea0, i <= 3); end
    end
    i_afull_thresh = 5'd17; i_aempty_thresh = 5'd0;
    #1;
    n_tests++; if (wfa0 !== 1'b0) begin n_fail++; $display("FAIL afull_17: got %b expected 0", wfa0); end
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      n_tests++; if (rea0 !== (q.size() == 0) || wfa0 !== 1'b0) begin n_fail++; $display("FAIL aempty_0: got rea=%b wfa=%b expected %b 0", rea0, wfa0, q.size() == 0); end
    end
  endtask

  task automatic test_fwft();
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    n_tests++; if (rdata1 !== 8'hA5) begin n_fail++; $display("FAIL fwft_a5: got %h expected a5", rdata1); end
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    n_tests++; if (rdata1 !== 8'hA5) begin n_fail++; $display("FAIL fwft_hold: got %h expected a5", rdata1); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (rdata1 !== 8'h5A || rdata0 !== 8'hA5) begin n_fail++; $display("FAIL fwft_pop: got %h/%h expected 5a/a5", rdata1, rdata0); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (rdata0 !== 8'h5A || rempty1 !== 1'b1) begin n_fail++; $display("FAIL fwft_last: got rdata0=%h rempty=%b expected 5a 1", rdata0, rempty1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int wp = ((c / 60) % 2 == 0) ? 75 : 25;
      if (c % 50 == 0) begin
        i_afull_thresh  = 5'($urandom_range(0, 17));
        i_aempty_thresh = 5'($urandom_range(0, 17));
      end
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp,
           8'($urandom), $urandom_range(0, 15) == 0);
      n_tests++; if (level0 !== 5'(q.size()) || level1 !== 5'(q.size())) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d/%0d expected %0d", c, level0, level1, q.size()); end
      n_tests++; if (wfull0 !== (q.size() == 16) || rempty0 !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_full_empty c%0d: got %b %b expected %b %b", c, wfull0, rempty0, q.size() == 16, q.size() == 0); end
      n_tests++; if (wfa0 !== (q.size() >= int'(i_afull_thresh)) || rea0 !== (q.size() <= int'(i_aempty_thresh))) begin n_fail++; $display("FAIL rnd_almost c%0d: got %b %b expected %b %b", c, wfa0, rea0, q.size() >= int'(i_afull_thresh), q.size() <= int'(i_aempty_thresh)); end
      n_tests++; if (ovf0 !== m_ovf || unf0 !== m_unf || ovf1 !== m_ovf || unf1 !== m_unf) begin n_fail++; $display("FAIL rnd_err c%0d: got %b %b expected %b %b", c, ovf0, unf0, m_ovf, m_unf); end
      n_tests++; if (rdata0 !== m_rreg) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c, rdata0, m_rreg); end
      if (q.size() != 0) begin
        n_tests++; if (rdata1 !== q[0]) begin n_fail++; $display("FAIL rnd_fwft c%0d: got %h expected %h", c, rdata1, q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    i_afull_thresh = 5'd16; i_aempty_thresh = 5'd2;
    i_reset_n = 1'b0; model_reset();
    #3 i_reset_n = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b0);
    n_tests++; if (level0 !== 5'd9 || rdata0 !== 8'h90) begin n_fail++; $display("FAIL pre_reset: got level=%0d rdata=%h expected 9 90", level0, rdata0); end
    i_reset_n = 1'b0; model_reset();
    #2;
    n_tests++; if (level0 !== 5'd0 || level1 !== 5'd0 || rempty0 !== 1'b1 || rempty1 !== 1'b1) begin n_fail++; $display("FAIL async_reset_level: got %0d/%0d rempty=%b expected 0 1", level0, level1, rempty0); end
    n_tests++; if (ovf0 !== 1'b0 || unf0 !== 1'b0 || rdata0 !== 8'h00 || rea0 !== 1'b1) begin n_fail++; $display("FAIL async_reset_flags: got ovf=%b unf=%b rdata=%h rea=%b expected 0 0 00 1", ovf0, unf0, rdata0, rea0); end
    #1 i_reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    n_tests++; if (rdata1 !== 8'h3C || level0 !== 5'd1) begin n_fail++; $display("FAIL post_reset_wr: got rdata1=%h level=%0d expected 3c 1", rdata1, level0); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (rdata0 !== 8'h3C || rempty0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_rd: got rdata0=%h rempty=%b expected 3c 1", rdata0, rempty0); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_boundaries();
    test_thresholds();
    test_fwft();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
